// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// New frame data is staged on load and swapped into the shadow bank at frame wrap.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_digit_data,
  input  logic [7:0]  i_digit_en,
  input  logic [7:0]  i_dp_mask,
  input  logic        i_load,
  output logic [7:0]  o_anode,
  output logic [7:0]  o_cathode,
  output logic        o_frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  // With no blanking gap every slot starts straight in DRIVE
  localparam state_t ST_RST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [31:0] r_stg_data;
  logic [7:0]  r_stg_en;
  logic [7:0]  r_stg_dp;
  logic        r_pending;
  logic [31:0] r_shd_data;
  logic [7:0]  r_shd_en;
  logic [7:0]  r_shd_dp;
  logic        w_slot_end;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic [7:0]  w_seg;
  logic [7:0]  w_anode;
  logic [7:0]  w_cathode;

  always_comb begin
    w_slot_end  = (r_cnt == LAST);
    w_wrap      = w_slot_end && (r_idx == 3'd7);
    w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = w_slot_end ? r_idx + 3'd1 : r_idx;
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BLANK: if (w_cnt_nxt == BLK) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (w_slot_end && BLK != '0) w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    w_nib = r_shd_data[{r_idx, 2'b00} +: 4];
    case (w_nib)
      4'h0:    w_seg = 8'b00000011;
      4'h1:    w_seg = 8'b10011111;
      4'h2:    w_seg = 8'b00100101;
      4'h3:    w_seg = 8'b00001101;
      4'h4:    w_seg = 8'b10011001;
      4'h5:    w_seg = 8'b01001001;
      4'h6:    w_seg = 8'b01000001;
      4'h7:    w_seg = 8'b00011111;
      4'h8:    w_seg = 8'b00000001;
      4'h9:    w_seg = 8'b00001001;
      4'hA:    w_seg = 8'b00010001;
      4'hB:    w_seg = 8'b11000001;
      4'hC:    w_seg = 8'b01100011;
      4'hD:    w_seg = 8'b10000101;
      4'hE:    w_seg = 8'b01100001;
      default: w_seg = 8'b01110001;
    endcase
    w_anode   = 8'hFF;
    w_cathode = 8'hFF;
    if (r_state == ST_DRIVE && r_shd_en[r_idx]) begin
      w_anode   = ~(8'b1 << r_idx);
      w_cathode = {w_seg[7:1], w_seg[0] & ~r_shd_dp[r_idx]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_RST;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_stg_data   <= '0;
      r_stg_en     <= '0;
      r_stg_dp     <= '0;
      r_pending    <= 1'b0;
      r_shd_data   <= '0;
      r_shd_en     <= '0;
      r_shd_dp     <= '0;
      o_anode      <= 8'hFF;
      o_cathode    <= 8'hFF;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      o_anode      <= w_anode;
      o_cathode    <= w_cathode;
      o_frame_done <= w_wrap;
      // Shadow swaps only at frame wrap so a frame is never mixed
      if (w_wrap && r_pending) begin
        r_shd_data <= r_stg_data;
        r_shd_en   <= r_stg_en;
        r_shd_dp   <= r_stg_dp;
      end
      if (i_load) begin
        r_stg_data <= i_digit_data;
        r_stg_en   <= i_digit_en;
        r_stg_dp   <= i_dp_mask;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
    end
  end

endmodule
